vm_payout_sequencer: RTL and testbench
======================================

Name: vm_payout_sequencer

Overview:
Change-payout controller for the vending machine. It accepts a change amount in cents from the vending FSM and owns the per-denomination coin/note inventory. It selects denominations greedily, from largest to smallest, and sequences them one at a time to the physical hopper over a valid/ack handshake. It reports completion, any undispensable remainder, and hopper faults (ack timeouts).

Parameters:
AMOUNT_W, 21, width of amounts in cents
CNT_W, 16, width of each inventory counter
INIT_COUNT, 100, reset value of every inventory counter
PAYOUT_MASK, 15'h7FFE, bit (code-1) set = denomination usable for change; default excludes code 1 (500.00)
TIMEOUT_CYCLES, 255, maximum cycles to wait for i_disp_ack

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  payout request valid
o_req_ready  out  1  sequencer idle, can accept a request
i_req_amount  in  AMOUNT_W  change to pay, in cents
i_deposit_valid  in  1  customer inserted a denomination
i_deposit_code  in  4  code of the inserted denomination (1..15)
o_disp_valid  out  1  hopper command valid
o_disp_code  out  4  denomination to eject
i_disp_ack  in  1  hopper ejected one unit
o_done  out  1  one-cycle pulse, payout finished
o_short  out  1  valid with o_done: remainder could not be paid
o_short_amount  out  AMOUNT_W  unpaid remainder, valid with o_done
o_fault  out  1  sticky: a hopper ack timeout occurred
i_inv_sel  in  4  inventory readback select
o_inv_count  out  CNT_W  combinational count for i_inv_sel; 0 for code 0

Behaviour:
- Clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values:
  - State IDLE.
  - All counters = INIT_COUNT.
  - o_req_ready = 1; all other outputs 0.
- Reset mid-payout aborts with no o_done.
- Denomination values in cents are fixed, by code 1..15: 50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100, 50, 25, 10, 5, 2, 1.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid: latch remaining = i_req_amount.
  - Go to DONE if the amount is 0, else to SELECT.
- SELECT (exactly 1 cycle):
  - Pick the lowest code c with PAYOUT_MASK[c-1] = 1, count[c] != 0, and value[c] <= remaining.
  - If one is found: latch o_disp_code = c, clear the timeout counter, go to DISPENSE.
  - If none is found: go to DONE.
- DISPENSE:
  - o_disp_valid = 1; o_disp_code is held stable.
  - On i_disp_ack: remaining -= value, count[c] -= 1, drop o_disp_valid next cycle.
    - If remaining == 0, go to DONE; else go to SELECT.
  - If TIMEOUT_CYCLES elapse without ack: set count[c] = 0 (hopper treated as empty), set o_fault, go to SELECT.
- DONE (1 cycle):
  - o_done = 1.
  - o_short = (remaining != 0); o_short_amount = remaining.
  - Then return to IDLE.
- Latency:
  - Request accepted at cycle N, nonzero amount: o_disp_valid high at N+2.
  - Each ack to the next o_disp_valid: 2 cycles.
  - Zero amount: o_done at N+1.
- i_disp_ack outside DISPENSE is ignored.
- o_fault clears only on reset.
- Deposits:
  - Accepted in any state: count[code] += 1 when i_deposit_valid.
  - Code 0 is ignored.
  - Counters saturate at all-ones.
- Deposit and ack on the same code in the same cycle: the count is unchanged.
- Decrement on timeout wins over a simultaneous deposit: the count becomes 1.
- remaining never underflows, because selection guarantees value <= remaining.
- o_req_ready = 0 outside IDLE; requests presented then are not consumed.

Decomposition:
- Package vm_pkg holds:
  - denomination code localparams and the 15-entry value table function;
  - state enum typedef;
  - AMOUNT_W default.
- Sub-module vm_denom_inventory holds the 15 counters, with deposit increment, dispense decrement, clear-on-timeout, saturation and readback mux.

Test Plan:
1. Reset.
   - All i_inv_sel 1..15 read 100.
   - o_req_ready = 1; o_done = 0; o_fault = 0.
2. Request 30 with immediate acks.
   - Dispenses code 11 (25), then code 13 (5).
   - o_done with o_short = 0.
   - Counts for codes 11 and 13 read 99.
3. Request 0.
   - o_done one cycle after acceptance, o_short = 0.
   - No o_disp_valid.
4. INIT_COUNT = 1, request 400.
   - Codes 8, 9, 10, 11, 12, 13, 14, 15 dispensed in order.
   - o_short = 1, o_short_amount = 7.
5. TIMEOUT_CYCLES = 8, request 200, code 8 never acked.
   - After 8 cycles: o_fault = 1, count for code 8 reads 0.
   - Next command is code 9, then a second code 9, then o_done with o_short = 0.
6. During a code 13 dispense, i_deposit_valid with code 13 in the same cycle as i_disp_ack.
   - Count for code 13 unchanged.
   - Count for code 1 increments on a code 1 deposit while busy.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine payout path: denomination codes,
// the code-to-cents value table and the payout sequencer state encoding.
package vm_pkg;

    localparam int unsigned AMOUNT_W_DEFAULT = 21;
    localparam int unsigned CODE_W           = 4;
    localparam int unsigned NUM_DENOM        = 15;
    localparam int unsigned VALUE_W          = 16;   // largest value 50000 fits

    // Denomination codes, named by value in cents; code 0 means "none"
    localparam logic [CODE_W-1:0] CODE_NONE  = 4'd0;
    localparam logic [CODE_W-1:0] CODE_50000 = 4'd1;
    localparam logic [CODE_W-1:0] CODE_20000 = 4'd2;
    localparam logic [CODE_W-1:0] CODE_10000 = 4'd3;
    localparam logic [CODE_W-1:0] CODE_5000  = 4'd4;
    localparam logic [CODE_W-1:0] CODE_2000  = 4'd5;
    localparam logic [CODE_W-1:0] CODE_1000  = 4'd6;
    localparam logic [CODE_W-1:0] CODE_500   = 4'd7;
    localparam logic [CODE_W-1:0] CODE_200   = 4'd8;
    localparam logic [CODE_W-1:0] CODE_100   = 4'd9;
    localparam logic [CODE_W-1:0] CODE_50    = 4'd10;
    localparam logic [CODE_W-1:0] CODE_25    = 4'd11;
    localparam logic [CODE_W-1:0] CODE_10    = 4'd12;
    localparam logic [CODE_W-1:0] CODE_5     = 4'd13;
    localparam logic [CODE_W-1:0] CODE_2     = 4'd14;
    localparam logic [CODE_W-1:0] CODE_1     = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE
    } state_t;

    // Value in cents of a denomination code; code 0 is worth nothing
    function automatic logic [VALUE_W-1:0] denom_value(input logic [CODE_W-1:0] code);
        logic [VALUE_W-1:0] v;
        case (code)
            CODE_50000: v = VALUE_W'(50000);
            CODE_20000: v = VALUE_W'(20000);
            CODE_10000: v = VALUE_W'(10000);
            CODE_5000:  v = VALUE_W'(5000);
            CODE_2000:  v = VALUE_W'(2000);
            CODE_1000:  v = VALUE_W'(1000);
            CODE_500:   v = VALUE_W'(500);
            CODE_200:   v = VALUE_W'(200);
            CODE_100:   v = VALUE_W'(100);
            CODE_50:    v = VALUE_W'(50);
            CODE_25:    v = VALUE_W'(25);
            CODE_10:    v = VALUE_W'(10);
            CODE_5:     v = VALUE_W'(5);
            CODE_2:     v = VALUE_W'(2);
            CODE_1:     v = VALUE_W'(1);
            CODE_NONE:  v = '0;
            default:    v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_denom_inventory.sv
// Per-denomination unit counters (codes 1..15).
// Ports: clk/rst_n (async active-low); deposit_valid/deposit_code add one unit;
// dec_valid/dec_code remove one dispensed unit; clr_valid/clr_code empty a
// counter after a hopper timeout; sel/sel_count combinational readback (code 0
// reads 0); nonzero flags a non-empty counter per code (bit = code-1).
module vm_denom_inventory
    import vm_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned INIT_COUNT = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 deposit_valid,
    input  logic [CODE_W-1:0]    deposit_code,
    input  logic                 dec_valid,
    input  logic [CODE_W-1:0]    dec_code,
    input  logic                 clr_valid,
    input  logic [CODE_W-1:0]    clr_code,
    input  logic [CODE_W-1:0]    sel,
    output logic [CNT_W-1:0]     sel_count,
    output logic [NUM_DENOM-1:0] nonzero
);

    logic [CNT_W-1:0]     count [NUM_DENOM];
    logic [NUM_DENOM-1:0] inc;
    logic [NUM_DENOM-1:0] dec;
    logic [NUM_DENOM-1:0] clr;

    // Decode the three update strobes per counter; code 0 matches nothing
    always_comb begin
        inc = '0;
        dec = '0;
        clr = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            inc[i] = deposit_valid && (deposit_code == CODE_W'(i + 1));
            dec[i] = dec_valid     && (dec_code     == CODE_W'(i + 1));
            clr[i] = clr_valid     && (clr_code     == CODE_W'(i + 1));
        end
    end

    // Clear beats decrement but still admits a same-cycle deposit;
    // a deposit and a dispense of the same code cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                count[i] <= CNT_W'(INIT_COUNT);
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                if (clr[i]) begin
                    count[i] <= inc[i] ? CNT_W'(1) : '0;
                end else if (inc[i] && !dec[i]) begin
                    if (count[i] != '1) begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end else if (dec[i] && !inc[i]) begin
                    if (count[i] != '0) begin
                        count[i] <= count[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            nonzero[i] = (count[i] != '0);
        end
    end

    always_comb begin
        sel_count = '0;
        if (sel != '0) begin
            sel_count = count[sel - CODE_W'(1)];
        end
    end

endmodule

// File: rtl/vm_payout_sequencer.sv
// Change-payout controller: greedy largest-first denomination selection,
// one-unit-at-a-time hopper handshake, completion/shortfall reporting and a
// sticky hopper-timeout fault.
// Ports: i_clk, i_rst_n (async active-low); i_req_valid/o_req_ready/
// i_req_amount payout request; i_deposit_valid/i_deposit_code inventory
// refill; o_disp_valid/o_disp_code/i_disp_ack hopper handshake; o_done,
// o_short, o_short_amount completion; o_fault sticky timeout; i_inv_sel/
// o_inv_count combinational inventory readback.
module vm_payout_sequencer
    import vm_pkg::*;
#(
    parameter int unsigned          AMOUNT_W       = AMOUNT_W_DEFAULT,
    parameter int unsigned          CNT_W          = 16,
    parameter int unsigned          INIT_COUNT     = 100,
    parameter logic [NUM_DENOM-1:0] PAYOUT_MASK    = 15'h7FFE,
    parameter int unsigned          TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [AMOUNT_W-1:0] i_req_amount,
    input  logic                i_deposit_valid,
    input  logic [3:0]          i_deposit_code,
    output logic                o_disp_valid,
    output logic [3:0]          o_disp_code,
    input  logic                i_disp_ack,
    output logic                o_done,
    output logic                o_short,
    output logic [AMOUNT_W-1:0] o_short_amount,
    output logic                o_fault,
    input  logic [3:0]          i_inv_sel,
    output logic [CNT_W-1:0]    o_inv_count
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t               state;
    logic [AMOUNT_W-1:0]  remaining;
    logic [TMR_W-1:0]     timer;
    logic [NUM_DENOM-1:0] nonzero;
    logic                 pick_found;
    logic [CODE_W-1:0]    pick_code;
    logic [AMOUNT_W-1:0]  disp_value;
    logic [AMOUNT_W-1:0]  rem_after;
    logic                 ack_now;
    logic                 timeout_now;

    assign disp_value  = AMOUNT_W'(denom_value(o_disp_code));
    assign rem_after   = remaining - disp_value;
    assign ack_now     = (state == ST_DISPENSE) && i_disp_ack;
    assign timeout_now = (state == ST_DISPENSE) && !i_disp_ack
                         && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    vm_denom_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inventory (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .deposit_valid (i_deposit_valid),
        .deposit_code  (i_deposit_code),
        .dec_valid     (ack_now),
        .dec_code      (o_disp_code),
        .clr_valid     (timeout_now),
        .clr_code      (o_disp_code),
        .sel           (i_inv_sel),
        .sel_count     (o_inv_count),
        .nonzero       (nonzero)
    );

    // Greedy pick: scan small-to-large value so the lowest code (largest value) wins
    always_comb begin
        pick_found = 1'b0;
        pick_code  = CODE_NONE;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (PAYOUT_MASK[i] && nonzero[i]
                && (AMOUNT_W'(denom_value(CODE_W'(i + 1))) <= remaining)) begin
                pick_found = 1'b1;
                pick_code  = CODE_W'(i + 1);
            end
        end
    end

    // Payout sequencer FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            remaining      <= '0;
            timer          <= '0;
            o_req_ready    <= 1'b1;
            o_disp_valid   <= 1'b0;
            o_disp_code    <= CODE_NONE;
            o_done         <= 1'b0;
            o_short        <= 1'b0;
            o_short_amount <= '0;
            o_fault        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        remaining   <= i_req_amount;
                        o_req_ready <= 1'b0;
                        if (i_req_amount == '0) begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    if (pick_found) begin
                        o_disp_code  <= pick_code;
                        o_disp_valid <= 1'b1;
                        timer        <= '0;
                        state        <= ST_DISPENSE;
                    end else begin
                        o_done         <= 1'b1;
                        o_short        <= (remaining != '0);
                        o_short_amount <= remaining;
                        state          <= ST_DONE;
                    end
                end
                ST_DISPENSE: begin
                    if (i_disp_ack) begin
                        remaining    <= rem_after;
                        o_disp_valid <= 1'b0;
                        if (rem_after == '0) begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_SELECT;
                        end
                    end else if (timeout_now) begin
                        // Hopper treated as empty for this code; retry with the rest
                        o_disp_valid <= 1'b0;
                        o_fault      <= 1'b1;
                        state        <= ST_SELECT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    o_done         <= 1'b0;
                    o_short        <= 1'b0;
                    o_short_amount <= '0;
                    o_req_ready    <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_payout_sequencer.sv
// Directed bench for vm_payout_sequencer. Instance A uses default parameters;
// instance B uses INIT_COUNT=1 and TIMEOUT_CYCLES=8. dsel routes the shared
// stimulus to one instance and selects its outputs for checking.
module tb_vm_payout_sequencer;

    localparam int unsigned AW = 21;
    localparam int unsigned CW = 16;

    typedef logic [3:0] codes_t [8];
    typedef struct {
        logic [AW-1:0] amount;
        int            n;
        codes_t        codes;
        logic          short_f;
        logic [AW-1:0] short_amt;
    } pay_vec_t;
    typedef struct {
        logic [3:0]  code;
        int unsigned count;
    } inv_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          dsel;
    logic          req_valid;
    logic [AW-1:0] req_amount;
    logic          deposit_valid;
    logic [3:0]    deposit_code;
    logic          disp_ack;
    logic [3:0]    inv_sel;

    logic          a_req_ready, a_disp_valid, a_done, a_short, a_fault;
    logic [3:0]    a_disp_code;
    logic [AW-1:0] a_short_amount;
    logic [CW-1:0] a_inv_count;
    logic          b_req_ready, b_disp_valid, b_done, b_short, b_fault;
    logic [3:0]    b_disp_code;
    logic [AW-1:0] b_short_amount;
    logic [CW-1:0] b_inv_count;

    logic          req_ready, disp_valid, done, short_f, fault;
    logic [3:0]    disp_code;
    logic [AW-1:0] short_amount;
    logic [CW-1:0] inv_count;

    assign req_ready    = dsel ? b_req_ready    : a_req_ready;
    assign disp_valid   = dsel ? b_disp_valid   : a_disp_valid;
    assign disp_code    = dsel ? b_disp_code    : a_disp_code;
    assign done         = dsel ? b_done         : a_done;
    assign short_f      = dsel ? b_short        : a_short;
    assign short_amount = dsel ? b_short_amount : a_short_amount;
    assign fault        = dsel ? b_fault        : a_fault;
    assign inv_count    = dsel ? b_inv_count    : a_inv_count;

    vm_payout_sequencer u_dut_a (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid & ~dsel),
        .o_req_ready     (a_req_ready),
        .i_req_amount    (req_amount),
        .i_deposit_valid (deposit_valid & ~dsel),
        .i_deposit_code  (deposit_code),
        .o_disp_valid    (a_disp_valid),
        .o_disp_code     (a_disp_code),
        .i_disp_ack      (disp_ack & ~dsel),
        .o_done          (a_done),
        .o_short         (a_short),
        .o_short_amount  (a_short_amount),
        .o_fault         (a_fault),
        .i_inv_sel       (inv_sel),
        .o_inv_count     (a_inv_count)
    );

    vm_payout_sequencer #(
        .INIT_COUNT     (1),
        .TIMEOUT_CYCLES (8)
    ) u_dut_b (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid & dsel),
        .o_req_ready     (b_req_ready),
        .i_req_amount    (req_amount),
        .i_deposit_valid (deposit_valid & dsel),
        .i_deposit_code  (deposit_code),
        .o_disp_valid    (b_disp_valid),
        .o_disp_code     (b_disp_code),
        .i_disp_ack      (disp_ack & dsel),
        .o_done          (b_done),
        .o_short         (b_short),
        .o_short_amount  (b_short_amount),
        .o_fault         (b_fault),
        .i_inv_sel       (inv_sel),
        .o_inv_count     (b_inv_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_inv(input string name, input logic [3:0] code, input int unsigned exp);
        inv_sel = code;
        #1;
        check($sformatf("%s inv[%0d]", name, code), 64'(inv_count), 64'(exp));
    endtask

    // Packed codes: nibble i (bits 4i+3..4i) is the i-th expected command
    function automatic pay_vec_t mk_pay(input logic [AW-1:0] amt, input logic sh,
                                        input logic [AW-1:0] sa, input int n,
                                        input logic [31:0] pc);
        pay_vec_t v;
        v.amount    = amt;
        v.n         = n;
        v.short_f   = sh;
        v.short_amt = sa;
        for (int i = 0; i < 8; i++) begin
            v.codes[i] = pc[4*i +: 4];
        end
        return v;
    endfunction

    // Run one payout on the selected instance.
    // stall > 0: the first command (stall_code) is never acked and must be held
    // exactly `stall` cycles; dep_first is then deposited in the timeout cycle.
    // stall == 0: every command is acked at once; dep_first rides on the first ack.
    // dep_busy is deposited in the cycle after acceptance.
    task automatic do_payout(input string name, input pay_vec_t v, input int stall,
                             input logic [3:0] stall_code, input logic [3:0] dep_busy,
                             input logic [3:0] dep_first);
        int t;
        int idx;
        int hold;
        int exp_t;
        bit stalling;
        bit finished;
        idx      = 0;
        hold     = 0;
        stalling = (stall > 0);
        finished = 1'b0;
        exp_t    = v.short_f ? 2*v.n + 2 : ((v.n == 0) ? 1 : 2*v.n + 1);
        @(negedge clk);
        check({name, " ready"}, 64'(req_ready), 64'(1));
        req_valid  = 1'b1;
        req_amount = v.amount;
        @(negedge clk);
        req_valid = 1'b0;
        t = 1;
        while (!finished && t < 400) begin
            disp_ack      = 1'b0;
            deposit_valid = 1'b0;
            deposit_code  = 4'd0;
            if (t == 1 && dep_busy != 4'd0) begin
                deposit_valid = 1'b1;
                deposit_code  = dep_busy;
            end
            if (done) begin
                finished = 1'b1;
                check({name, " cmd count"}, 64'(idx), 64'(v.n));
                check({name, " short"}, 64'(short_f), 64'(v.short_f));
                check({name, " short_amount"}, 64'(short_amount), 64'(v.short_amt));
                if (stall == 0) check({name, " done cycle"}, 64'(t), 64'(exp_t));
            end else if (disp_valid) begin
                if (stalling) begin
                    if (hold == 0) check({name, " stalled code"}, 64'(disp_code), 64'(stall_code));
                    hold++;
                    if (hold == stall && dep_first != 4'd0) begin
                        deposit_valid = 1'b1;
                        deposit_code  = dep_first;
                    end
                end else begin
                    if (idx < v.n) begin
                        check($sformatf("%s code[%0d]", name, idx), 64'(disp_code), 64'(v.codes[idx]));
                    end else begin
                        check({name, " extra cmd"}, 64'(idx), 64'(v.n));
                    end
                    if (stall == 0) check($sformatf("%s latency[%0d]", name, idx), 64'(t), 64'(2*(idx+1)));
                    if (idx == 0) check({name, " busy ready"}, 64'(req_ready), 64'(0));
                    if (idx == 0 && stall == 0 && dep_first != 4'd0) begin
                        deposit_valid = 1'b1;
                        deposit_code  = dep_first;
                    end
                    disp_ack = 1'b1;
                    idx++;
                end
            end else if (stalling && hold > 0) begin
                stalling = 1'b0;
                check({name, " hold cycles"}, 64'(hold), 64'(stall));
                check({name, " fault set"}, 64'(fault), 64'(1));
            end
            @(negedge clk);
            t++;
        end
        disp_ack      = 1'b0;
        deposit_valid = 1'b0;
        deposit_code  = 4'd0;
        check({name, " finished"}, 64'(finished), 64'(1));
        check({name, " done pulse"}, 64'(done), 64'(0));
        check({name, " ready after"}, 64'(req_ready), 64'(1));
    endtask

    task automatic deposit(input logic [3:0] code);
        @(negedge clk);
        deposit_valid = 1'b1;
        deposit_code  = code;
        @(negedge clk);
        deposit_valid = 1'b0;
        deposit_code  = 4'd0;
    endtask

    pay_vec_t pay_a [4];
    inv_vec_t inv_a [12];
    bit       seen_done;

    initial begin
        // Instance A payout table (default inventory 100, code 1 masked)
        pay_a[0] = mk_pay(21'd30,    1'b0, 21'd0, 2, 32'h0000_00DB);
        pay_a[1] = mk_pay(21'd0,     1'b0, 21'd0, 0, 32'h0000_0000);
        pay_a[2] = mk_pay(21'd287,   1'b0, 21'd0, 5, 32'h000E_CBA8);
        pay_a[3] = mk_pay(21'd50000, 1'b0, 21'd0, 3, 32'h0000_0322);
        // Instance A inventory after the table and the deposit/ack collision run
        inv_a[0]  = '{code: 4'd0,  count: 0};
        inv_a[1]  = '{code: 4'd1,  count: 101};
        inv_a[2]  = '{code: 4'd2,  count: 98};
        inv_a[3]  = '{code: 4'd3,  count: 99};
        inv_a[4]  = '{code: 4'd8,  count: 99};
        inv_a[5]  = '{code: 4'd9,  count: 100};
        inv_a[6]  = '{code: 4'd10, count: 99};
        inv_a[7]  = '{code: 4'd11, count: 98};
        inv_a[8]  = '{code: 4'd12, count: 99};
        inv_a[9]  = '{code: 4'd13, count: 99};
        inv_a[10] = '{code: 4'd14, count: 99};
        inv_a[11] = '{code: 4'd15, count: 100};

        rst_n         = 1'b0;
        dsel          = 1'b0;
        req_valid     = 1'b0;
        req_amount    = '0;
        deposit_valid = 1'b0;
        deposit_code  = 4'd0;
        disp_ack      = 1'b0;
        inv_sel       = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state, instance A
        check("rst ready", 64'(req_ready), 64'(1));
        check("rst done", 64'(done), 64'(0));
        check("rst fault", 64'(fault), 64'(0));
        check("rst disp_valid", 64'(disp_valid), 64'(0));
        check("rst short", 64'(short_f), 64'(0));
        for (int c = 1; c <= 15; c++) check_inv("rst", 4'(c), 100);
        check_inv("rst", 4'd0, 0);

        for (int i = 0; i < 4; i++) begin
            do_payout($sformatf("pay_a%0d", i), pay_a[i], 0, 4'd0, 4'd0, 4'd0);
        end
        check_inv("after30", 4'd11, 98);

        // Deposit+ack on code 13 cancels; code 1 deposit while busy counts
        do_payout("collide", mk_pay(21'd5, 1'b0, 21'd0, 1, 32'h0000_000D), 0, 4'd0, 4'd1, 4'd13);
        for (int i = 0; i < 12; i++) check_inv("inv_a", inv_a[i].code, inv_a[i].count);
        check("a fault clear", 64'(fault), 64'(0));

        // Instance B: one unit each, 8-cycle hopper timeout
        dsel = 1'b1;
        @(negedge clk);
        check("b rst fault", 64'(fault), 64'(0));
        check_inv("b rst", 4'd8, 1);
        check_inv("b rst", 4'd15, 1);
        do_payout("short400", mk_pay(21'd400, 1'b1, 21'd7, 8, 32'hFEDC_BA98), 0, 4'd0, 4'd0, 4'd0);
        for (int c = 8; c <= 15; c++) check_inv("b empty", 4'(c), 0);
        check_inv("b code7", 4'd7, 1);
        check("b no fault", 64'(fault), 64'(0));

        deposit(4'd8);
        deposit(4'd9);
        deposit(4'd9);
        deposit(4'd0);
        check_inv("refill", 4'd8, 1);
        check_inv("refill", 4'd9, 2);

        do_payout("timeout", mk_pay(21'd200, 1'b0, 21'd0, 2, 32'h0000_0099), 8, 4'd8, 4'd0, 4'd0);
        check_inv("timeout", 4'd8, 0);
        check_inv("timeout", 4'd9, 0);

        // Timeout clear coincident with a deposit leaves one unit, which is retried
        deposit(4'd8);
        do_payout("tmo_dep", mk_pay(21'd200, 1'b0, 21'd0, 1, 32'h0000_0008), 8, 4'd8, 4'd0, 4'd8);
        check_inv("tmo_dep", 4'd8, 0);

        do_payout("b zero", mk_pay(21'd0, 1'b0, 21'd0, 0, 32'h0), 0, 4'd0, 4'd0, 4'd0);
        check("fault sticky", 64'(fault), 64'(1));

        // Reset in the middle of a payout on A: no done, inventory restored
        dsel = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 21'd100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst disp_valid", 64'(disp_valid), 64'(1));
        check("midrst code", 64'(disp_code), 64'(9));
        rst_n = 1'b0;
        #1;
        check("midrst valid low", 64'(disp_valid), 64'(0));
        check("midrst ready", 64'(req_ready), 64'(1));
        check_inv("midrst", 4'd11, 100);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst no done", 64'(seen_done), 64'(0));
        dsel = 1'b1;
        #1;
        check("b fault reset", 64'(fault), 64'(0));
        check_inv("b reset", 4'd8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
